// File: rtl/uart_pkg.sv
// Shared UART definitions: port decode constant, transmit FSM encoding and
// default buffer depth used by the transmit and receive byte buffers.
package uart_pkg;

  localparam logic [15:0] UART_DATA_PORT = 16'h0000;
  localparam int          UART_TX_DEPTH  = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_RDY  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// Generic DEPTH x 8 byte FIFO with registered count/full/empty and
// read-before-write behaviour when a push lands on the slot being popped.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_TX_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic          drop,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count_nxt;
  logic          pop_ok;
  logic          accept;

  // A push into a full buffer is still accepted when a pop frees a slot
  // on the same edge; the pop sees the old contents of that slot.
  assign pop_ok = pop & ~empty;
  assign accept = push & (~full | pop_ok);
  assign drop   = push & full & ~pop_ok;
  assign dout   = mem[rptr];

  always_comb begin
    count_nxt = count;
    unique case ({accept, pop_ok})
      2'b10:   count_nxt = count + (AW + 1)'(1);
      2'b01:   count_nxt = count - (AW + 1)'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (accept) wptr <= wptr + AW'(1);
      if (pop_ok) rptr <= rptr + AW'(1);
      count <= count_nxt;
      full  <= (count_nxt == FULL_CNT);
      empty <= (count_nxt == '0);
    end
  end

  // Storage carries no reset; occupancy alone says which entries are valid.
  always_ff @(posedge clk) begin
    if (accept) mem[wptr] <= din;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit byte buffer: queues processor writes and hands them one at a time
// to the UART transmit engine over its load/txrdy handshake.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_TX_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr,
  input  logic [7:0]    din,
  input  logic          txrdy,
  input  logic          clr_ovr,
  output logic          load,
  output logic [7:0]    tx_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          ovr
);

  tx_state_t  state;
  tx_state_t  state_nxt;
  logic       pop;
  logic       drop;
  logic [7:0] head;

  uart_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .push  (wr),
    .pop   (pop),
    .din   (din),
    .dout  (head),
    .drop  (drop),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign pop = (state == IDLE) & ~empty & txrdy;

  // After a load, wait for the engine to go busy and then idle again so a
  // slow txrdy drop can never cause the same byte to be loaded twice.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (pop)    state_nxt = LOAD;
      LOAD:                  state_nxt = WAIT_BUSY;
      WAIT_BUSY: if (!txrdy) state_nxt = WAIT_RDY;
      WAIT_RDY:  if (txrdy)  state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      load    <= 1'b0;
      tx_data <= 8'h00;
      ovr     <= 1'b0;
    end else begin
      state <= state_nxt;
      load  <= pop;
      if (pop) tx_data <= head;
      if (drop)         ovr <= 1'b1;
      else if (clr_ovr) ovr <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a simple transmit-engine model that
// captures every loaded byte and goes busy for a programmable time.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr;
  logic [7:0] din;
  logic       txrdy;
  logic       clr_ovr;
  logic       load;
  logic [7:0] tx_data;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       ovr;

  int n_chk  = 0;
  int n_fail = 0;

  bit         eng_hold = 1'b0;
  bit         eng_rand = 1'b0;
  int         eng_busy = 3;
  int         busy_cnt = 0;
  logic [7:0] rxq [$];

  typedef struct {
    logic       wr;
    logic [7:0] din;
    logic       clr;
    logic [4:0] cnt;
    logic       full;
    logic       empty;
    logic       ovr;
  } vec_t;

  vec_t vt [$];

  uart_tx_fifo #(.DEPTH(16), .AW(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .wr      (wr),
    .din     (din),
    .txrdy   (txrdy),
    .clr_ovr (clr_ovr),
    .load    (load),
    .tx_data (tx_data),
    .full    (full),
    .empty   (empty),
    .count   (count),
    .ovr     (ovr)
  );

  always #5 clk = ~clk;

  // Engine model: samples load on the falling edge, then stays busy.
  initial begin
    txrdy = 1'b1;
    forever begin
      @(negedge clk);
      if (load && !reset) rxq.push_back(tx_data);
      if (reset) begin
        busy_cnt = 0;
        txrdy    = ~eng_hold;
      end else if (load) begin
        txrdy    = 1'b0;
        busy_cnt = eng_rand ? int'($urandom_range(50, 3)) : eng_busy;
      end else if (eng_hold) begin
        busy_cnt = 0;
        txrdy    = 1'b0;
      end else if (busy_cnt > 0) begin
        busy_cnt = busy_cnt - 1;
        txrdy    = (busy_cnt == 0);
      end else begin
        txrdy = 1'b1;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_count"}, 32'(count), 0);
    chk({tag, "_empty"}, 32'(empty), 1);
    chk({tag, "_full"}, 32'(full), 0);
    chk({tag, "_load"}, 32'(load), 0);
    chk({tag, "_ovr"}, 32'(ovr), 0);
    chk({tag, "_txdata"}, 32'(tx_data), 0);
  endtask

  task automatic wait_loads(input int n, input int budget, input string nm);
    int c = 0;
    while (rxq.size() < n && c < budget) begin
      tick();
      c++;
    end
    chk(nm, 32'(rxq.size()), 32'(n));
  endtask

  task automatic write_byte(input logic [7:0] b);
    wr  = 1'b1;
    din = b;
    tick();
    wr  = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_q [$];
    int         idx;
    int         budget;
    int         viol;
    int         nsnap;

    reset = 1'b1; wr = 1'b0; din = 8'h00; clr_ovr = 1'b0;
    tick(); tick();
    chk_reset_state("rst0");
    reset = 1'b0;
    tick();

    // Single byte with an idle engine that then stays busy for 1000 cycles.
    eng_busy = 1000;
    wr = 1'b1; din = 8'hA5;
    tick();
    wr = 1'b0;
    chk("single_count_e0", 32'(count), 1);
    chk("single_empty_e0", 32'(empty), 0);
    chk("single_load_e0", 32'(load), 0);
    tick();
    chk("single_load_e1", 32'(load), 1);
    chk("single_txdata_e1", 32'(tx_data), 32'h A5);
    chk("single_count_e1", 32'(count), 0);
    chk("single_empty_e1", 32'(empty), 1);
    tick();
    chk("single_load_e2", 32'(load), 0);
    repeat (1010) tick();
    chk("single_nloads", 32'(rxq.size()), 1);
    if (rxq.size() > 0) chk("single_byte", 32'(rxq[0]), 32'h A5);
    chk("single_txdata_hold", 32'(tx_data), 32'h A5);
    rxq.delete();

    // Burst and overrun vectors with the engine held busy.
    eng_busy = 3;
    eng_hold = 1'b1;
    tick(); tick();
    for (int i = 0; i < 16; i++)
      vt.push_back('{1'b1, 8'(i), 1'b0, 5'(i + 1), (i == 15), 1'b0, 1'b0});
    vt.push_back('{1'b1, 8'hFF, 1'b0, 5'd16, 1'b1, 1'b0, 1'b1});
    vt.push_back('{1'b0, 8'h00, 1'b0, 5'd16, 1'b1, 1'b0, 1'b1});
    vt.push_back('{1'b0, 8'h00, 1'b1, 5'd16, 1'b1, 1'b0, 1'b0});
    vt.push_back('{1'b1, 8'hFF, 1'b1, 5'd16, 1'b1, 1'b0, 1'b1});
    vt.push_back('{1'b0, 8'h00, 1'b1, 5'd16, 1'b1, 1'b0, 1'b0});
    for (int i = 0; i < vt.size(); i++) begin
      wr = vt[i].wr; din = vt[i].din; clr_ovr = vt[i].clr;
      tick();
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(vt[i].cnt));
      chk($sformatf("vec%0d_full", i), 32'(full), 32'(vt[i].full));
      chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(vt[i].empty));
      chk($sformatf("vec%0d_ovr", i), 32'(ovr), 32'(vt[i].ovr));
    end
    wr = 1'b0; clr_ovr = 1'b0;
    eng_hold = 1'b0;
    wait_loads(16, 600, "burst_nloads");
    repeat (20) tick();
    chk("burst_nloads_final", 32'(rxq.size()), 16);
    for (int i = 0; i < 16 && i < rxq.size(); i++)
      chk($sformatf("burst_byte%0d", i), 32'(rxq[i]), 32'(i));
    chk("burst_empty", 32'(empty), 1);
    rxq.delete();

    // Write landing on the exact pop edge of a full buffer.
    eng_hold = 1'b1;
    tick(); tick();
    for (int i = 0; i < 16; i++) write_byte(8'h20 + 8'(i));
    chk("fp_full_before", 32'(full), 1);
    chk("fp_count_before", 32'(count), 16);
    eng_hold = 1'b0;
    wr = 1'b1; din = 8'h5A;
    tick();
    wr = 1'b0;
    chk("fp_count", 32'(count), 16);
    chk("fp_full", 32'(full), 1);
    chk("fp_ovr", 32'(ovr), 0);
    chk("fp_load", 32'(load), 1);
    chk("fp_txdata", 32'(tx_data), 32'h 20);
    wait_loads(17, 700, "fp_nloads");
    for (int i = 0; i < 17 && i < rxq.size(); i++)
      chk($sformatf("fp_byte%0d", i), 32'(rxq[i]), (i == 16) ? 32'h 5A : 32'h 20 + 32'(i));
    rxq.delete();

    // Reset with bytes queued and a byte already loaded.
    eng_hold = 1'b1;
    tick(); tick();
    for (int i = 0; i < 5; i++) write_byte(8'h31 + 8'(i));
    eng_hold = 1'b0;
    wait_loads(1, 50, "rst_first_load");
    eng_hold = 1'b1;
    tick();
    chk("rst_count_before", 32'(count), 4);
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    chk_reset_state("rst1");
    eng_hold = 1'b0;
    nsnap = rxq.size();
    repeat (40) tick();
    chk("rst_no_load", 32'(rxq.size()), 32'(nsnap));
    chk("rst_empty_after", 32'(empty), 1);
    rxq.delete();

    // Random stream through pointer wrap with random engine busy times.
    eng_rand = 1'b1;
    for (int i = 0; i < 40; i++) exp_q.push_back(8'($urandom_range(255, 0)));
    idx = 0; budget = 0; viol = 0;
    while ((idx < 40 || rxq.size() < 40) && budget < 20000) begin
      if (idx < 40 && !full && $urandom_range(1, 0) == 1) begin
        wr = 1'b1; din = exp_q[idx]; idx++;
      end else begin
        wr = 1'b0;
      end
      tick();
      budget++;
      if (count > 5'd16 || (empty != (count == 5'd0)) || (full != (count == 5'd16)))
        viol++;
    end
    wr = 1'b0;
    chk("rand_nloads", 32'(rxq.size()), 40);
    chk("rand_count_violations", 32'(viol), 0);
    for (int i = 0; i < 40 && i < rxq.size(); i++)
      chk($sformatf("rand_byte%0d", i), 32'(rxq[i]), 32'(exp_q[i]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
